// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined WIDTH-bit ALU with N/Z/C/V flags and valid/ready on both sides.
module alu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_carry,
    output logic             out_ovf
);
    localparam int SHW = $clog2(WIDTH);
    logic             s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [2:0]       op_q, op_d;
    logic             zero_q, zero_d, neg_q, neg_d, carry_q, carry_d, ovf_q, ovf_d;
    logic             s2_free, s1_adv, accept;
    logic [WIDTH:0]   sum, diff;
    logic [SHW-1:0]   amt;
    logic [WIDTH-1:0] alu;
    logic             alu_c, alu_v;
    always_comb begin
        s2_free  = !s2_valid_q | out_ready;
        s1_adv   = s1_valid_q & s2_free;
        in_ready = !rst & (!s1_valid_q | s2_free);
        accept   = in_valid & in_ready;
        sum      = {1'b0, a_q} + {1'b0, b_q};
        diff     = {1'b0, a_q} - {1'b0, b_q};
        amt      = b_q[SHW-1:0];
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        // Shifts by >= WIDTH (non-power-of-2 WIDTH) naturally produce 0.
        case (op_q)
            3'd0: begin
                alu   = sum[WIDTH-1:0];
                alu_c = sum[WIDTH];
                alu_v = (a_q[WIDTH-1] == b_q[WIDTH-1]) & (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            3'd1: begin
                alu   = diff[WIDTH-1:0];
                alu_c = diff[WIDTH];
                alu_v = (a_q[WIDTH-1] != b_q[WIDTH-1]) & (diff[WIDTH-1] != a_q[WIDTH-1]);
            end
            3'd2:    alu = a_q & b_q;
            3'd3:    alu = a_q | b_q;
            3'd4:    alu = a_q ^ b_q;
            3'd5:    alu = {{(WIDTH-1){1'b0}}, $signed(a_q) < $signed(b_q)};
            3'd6:    alu = a_q << amt;
            default: alu = a_q >> amt;
        endcase
        s1_valid_d = accept | (s1_valid_q & !s2_free);
        a_d        = accept ? in_a : a_q;
        b_d        = accept ? in_b : b_q;
        op_d       = accept ? in_op : op_q;
        s2_valid_d = s2_free ? s1_valid_q : s2_valid_q;
        res_d      = s1_adv ? alu : res_q;
        zero_d     = s1_adv ? (alu == '0) : zero_q;
        neg_d      = s1_adv ? alu[WIDTH-1] : neg_q;
        carry_d    = s1_adv ? alu_c : carry_q;
        ovf_d      = s1_adv ? alu_v : ovf_q;
        out_valid  = s2_valid_q;
        out_result = res_q;
        out_zero   = zero_q;
        out_neg    = neg_q;
        out_carry  = carry_q;
        out_ovf    = ovf_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            res_q      <= '0;
            zero_q     <= 1'b0;
            neg_q      <= 1'b0;
            carry_q    <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            res_q      <= res_d;
            zero_q     <= zero_d;
            neg_q      <= neg_d;
            carry_q    <= carry_d;
            ovf_q      <= ovf_d;
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: table vectors, handshake corner sequences and a random scoreboard run
// against an arithmetic reference model; WIDTH=4/32 instances cover ADD/SUB corners.
module tb_alu_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, out_ready = 1'b0;
    logic [2:0]  in_op = '0;
    logic [7:0]  in_a = '0, in_b = '0;
    logic [3:0]  a4 = '0, b4 = '0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        in_ready, out_valid, o_z, o_n, o_c, o_v;
    logic [7:0]  o_res;
    logic        rdy4, val4, z4, n4, c4, v4, rdy32, val32, z32, n32, c32, v32;
    logic [3:0]  res4;
    logic [31:0] res32;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(o_res), .out_zero(o_z), .out_neg(o_n), .out_carry(o_c), .out_ovf(o_v));
    alu_pipe #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4),
        .in_a(a4), .in_b(b4), .in_op(in_op), .out_valid(val4), .out_ready(out_ready),
        .out_result(res4), .out_zero(z4), .out_neg(n4), .out_carry(c4), .out_ovf(v4));
    alu_pipe #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy32),
        .in_a(a32), .in_b(b32), .in_op(in_op), .out_valid(val32), .out_ready(out_ready),
        .out_result(res32), .out_zero(z32), .out_neg(n32), .out_carry(c32), .out_ovf(v32));

    typedef struct packed {logic [63:0] r; logic [3:0] f;} res_t;
    typedef struct {logic [7:0] a; logic [7:0] b; logic [2:0] op; logic [7:0] r; logic [3:0] f;} vec_t;

    int   n_chk = 0, n_pass = 0, rcv = 0, sent = 0;
    res_t exp_q[$];
    logic stalled_prev = 1'b0;
    logic [11:0] prev_out = '0;
    vec_t tbl[13];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    // Reference: plain integer arithmetic on the signed/unsigned meaning of the operands.
    function automatic res_t model(input int w, input longint unsigned a, input longint unsigned b, input int op);
        longint unsigned m = (64'd1 << w) - 1;
        longint sa = a[w-1] ? longint'(a) - longint'(64'd1 << w) : longint'(a);
        longint sb = b[w-1] ? longint'(b) - longint'(64'd1 << w) : longint'(b);
        longint maxs = longint'(64'd1 << (w - 1)) - 1;
        longint mins = -longint'(64'd1 << (w - 1));
        longint unsigned amt = b % longint'($clog2(w) == 0 ? 1 : (64'd1 << $clog2(w)));
        longint unsigned r = 0;
        logic c = 0, v = 0;
        case (op)
            0: begin r = (a + b) & m; c = (a + b) > m; v = (sa + sb > maxs) || (sa + sb < mins); end
            1: begin r = (a - b) & m; c = a < b; v = (sa - sb > maxs) || (sa - sb < mins); end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = (sa < sb) ? 1 : 0;
            6: r = (amt >= longint'(w)) ? 0 : (a << amt) & m;
            default: r = (amt >= longint'(w)) ? 0 : a >> amt;
        endcase
        model.r = r;
        model.f = {r == 0, r[w-1], c, v};
    endfunction

    // One clock cycle: drive, sample at negedge, update scoreboard, return at posedge+1.
    task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                        input logic rdy, output logic acc);
        res_t e;
        in_valid = v; in_a = a; in_b = b; in_op = op; out_ready = rdy;
        @(negedge clk);
        acc = in_valid & in_ready;
        if (stalled_prev) chk("stall_hold", {o_res, o_z, o_n, o_c, o_v}, prev_out);
        if (out_valid & out_ready) begin
            rcv++;
            if (exp_q.size() == 0) chk("unexpected_beat", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("sb_result", o_res, e.r);
                chk("sb_flags", {o_z, o_n, o_c, o_v}, e.f);
            end
        end
        if (acc) exp_q.push_back(model(8, a, b, op));
        stalled_prev = out_valid & !out_ready;
        prev_out = {o_res, o_z, o_n, o_c, o_v};
        @(posedge clk); #1;
    endtask

    function automatic longint unsigned kval(input int k, input int w);
        case (k)
            0: kval = 1;
            1: kval = (64'd1 << w) - 1;
            2: kval = (64'd1 << (w - 1)) - 1;
            3: kval = 64'd1 << (w - 1);
            default: kval = 2;
        endcase
    endfunction

    initial begin
        logic acc;
        int ka[4] = '{1, 2, 3, 0};
        int kb[4] = '{0, 0, 0, 4};
        int kop[4] = '{0, 0, 1, 1};
        res_t e4, e8, e32;
        tbl[0]  = '{8'hFF, 8'h01, 3'd0, 8'h00, 4'b1010};
        tbl[1]  = '{8'h80, 8'h01, 3'd1, 8'h7F, 4'b0001};
        tbl[2]  = '{8'h01, 8'h02, 3'd1, 8'hFF, 4'b0110};
        tbl[3]  = '{8'hFE, 8'h01, 3'd5, 8'h01, 4'b0000};
        tbl[4]  = '{8'h81, 8'h03, 3'd6, 8'h08, 4'b0000};
        tbl[5]  = '{8'h80, 8'h07, 3'd7, 8'h01, 4'b0000};
        tbl[6]  = '{8'hF0, 8'h3C, 3'd2, 8'h30, 4'b0000};
        tbl[7]  = '{8'hF0, 8'h0F, 3'd3, 8'hFF, 4'b0100};
        tbl[8]  = '{8'hAA, 8'hAA, 3'd4, 8'h00, 4'b1000};
        tbl[9]  = '{8'h7F, 8'h01, 3'd0, 8'h80, 4'b0101};
        tbl[10] = '{8'h01, 8'hFE, 3'd5, 8'h00, 4'b1000};
        tbl[11] = '{8'h05, 8'h05, 3'd1, 8'h00, 4'b1000};
        tbl[12] = '{8'h01, 8'h0B, 3'd6, 8'h08, 4'b0000};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_outputs", {o_res, o_z, o_n, o_c, o_v}, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        foreach (tbl[i]) begin
            in_valid = 1'b1; in_a = tbl[i].a; in_b = tbl[i].b; in_op = tbl[i].op; out_ready = 1'b1;
            @(negedge clk);
            chk("tbl_in_ready", in_ready, 1);
            @(posedge clk); #1 in_valid = 1'b0; in_a = $urandom; in_b = $urandom;
            @(negedge clk);
            chk("tbl_latency_n1", out_valid, 0);
            @(posedge clk);
            @(negedge clk);
            chk("tbl_latency_n2", out_valid, 1);
            chk($sformatf("tbl%0d_result", i), o_res, tbl[i].r);
            chk($sformatf("tbl%0d_flags", i), {o_z, o_n, o_c, o_v}, tbl[i].f);
            @(posedge clk); #1;
        end

        for (int i = 0; i < 4; i++) begin
            a4 = 4'(kval(ka[i], 4)); b4 = 4'(kval(kb[i], 4));
            in_a = 8'(kval(ka[i], 8)); in_b = 8'(kval(kb[i], 8));
            a32 = 32'(kval(ka[i], 32)); b32 = 32'(kval(kb[i], 32));
            in_op = 3'(kop[i]); in_valid = 1'b1; out_ready = 1'b1;
            e4 = model(4, a4, b4, kop[i]); e8 = model(8, in_a, in_b, kop[i]); e32 = model(32, a32, b32, kop[i]);
            @(posedge clk); #1 in_valid = 1'b0;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("w4_case%0d", i), {val4, res4, z4, n4, c4, v4}, {1'b1, e4.r[3:0], e4.f});
            chk($sformatf("w8_case%0d", i), {out_valid, o_res, o_z, o_n, o_c, o_v}, {1'b1, e8.r[7:0], e8.f});
            chk($sformatf("w32_case%0d", i), {val32, res32, z32, n32, c32, v32}, {1'b1, e32.r[31:0], e32.f});
            @(posedge clk); #1;
        end

        stalled_prev = 1'b0;
        step(1, 8'h10, 8'h20, 3'd0, 0, acc); chk("bp_beat1_acc", acc, 1);
        step(1, 8'h33, 8'h11, 3'd1, 0, acc); chk("bp_beat2_acc", acc, 1);
        step(1, 8'hC3, 8'h0F, 3'd4, 0, acc); chk("bp_beat3_blocked", acc, 0);
        step(1, 8'hC3, 8'h0F, 3'd4, 0, acc); chk("bp_beat3_blocked2", acc, 0);
        step(1, 8'hC3, 8'h0F, 3'd4, 1, acc); chk("bp_beat3_acc_on_retire", acc, 1);
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) step(0, 8'h00, 8'h00, 3'd0, 1, acc);
        chk("bp_drained", exp_q.size(), 0);

        rcv = 0;
        for (int c = 0; c < 2000 && (sent < 40 || exp_q.size() > 0); c++) begin
            step(sent < 40 ? ($urandom_range(0, 3) != 0) : 1'b0, 8'($urandom), 8'($urandom),
                 3'($urandom), 1'($urandom_range(0, 1)), acc);
            if (acc) sent++;
        end
        chk("rand_sent", sent, 40);
        chk("rand_received", rcv, 40);
        chk("rand_queue_empty", exp_q.size(), 0);

        step(1, 8'h01, 8'h02, 3'd0, 0, acc);
        step(1, 8'h03, 8'h04, 3'd0, 0, acc);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", in_ready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_outputs", {o_res, o_z, o_n, o_c, o_v}, 0);
        chk("midrst_in_ready2", in_ready, 0);
        @(posedge clk); #1 rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        exp_q.delete();
        stalled_prev = 1'b0;
        @(negedge clk);
        chk("midrst_release_ready", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        chk("midrst_no_ghost", out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
